// File: rtl/knn_distance_engine.sv
// ---------------------------------------------------------------------------
// knn_distance_engine
//
// Upstream feeder for the k-nearest-neighbour sorter. Holds a table of
// labelled 2-D training points. On start it latches a query point and walks
// every table address, streaming one distance/label pair per cycle for each
// valid entry. Invalid entries still consume their slot, so the stream is
// never compacted.
//
// Optional build macro:
//   KNN_EUCLID_EN  undefined : Manhattan distance |dx| + |dy| (max 30)
//                  defined   : squared Euclidean dx^2 + dy^2, saturated to 30
//   Distance 31 is never produced because it is the sorter's empty sentinel.
//
// Ports:
//   clk          clock
//   rst          asynchronous, active-high reset
//   wr_en        table write strobe (honoured only while idle)
//   wr_addr      table write address
//   wr_x, wr_y   training point coordinates
//   wr_label     training point class
//   start        begin a query (honoured only while idle)
//   query_x/y    query point, latched together with start
//   knn_clr      one-cycle clear pulse for the downstream sorter
//   dist_out     distance to the sorter's data_in
//   label_out    label to the sorter's label_in
//   dist_valid   to the sorter's enable
//   busy         query in progress
//   done         one-cycle completion pulse
//
// Timing, start sampled at edge T: knn_clr in T+1, addresses issued
// T+2..T+N_SAMPLES+1, results T+4..T+N_SAMPLES+3, done in T+N_SAMPLES+4.
// ---------------------------------------------------------------------------
module knn_distance_engine #(
    parameter int N_SAMPLES = 16,
    parameter int AW        = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [3:0]    wr_x,
    input  logic [3:0]    wr_y,
    input  logic [1:0]    wr_label,
    input  logic          start,
    input  logic [3:0]    query_x,
    input  logic [3:0]    query_y,
    output logic          knn_clr,
    output logic [4:0]    dist_out,
    output logic [1:0]    label_out,
    output logic          dist_valid,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            drain_q, drain_d;

    logic [3:0]      qx_q, qy_q;

    logic [3:0]      tbl_x [N_SAMPLES];
    logic [3:0]      tbl_y [N_SAMPLES];
    logic [1:0]      tbl_lbl [N_SAMPLES];
    logic [N_SAMPLES-1:0] tbl_vld_q;

    logic            wr_ok;
    logic            start_ok;

    logic [3:0]      x_p1_q, y_p1_q;
    logic [1:0]      lbl_p1_q;
    logic            vld_p1_q;

    logic [4:0]      dist_p2_q;
    logic [1:0]      lbl_p2_q;
    logic            vld_p2_q;

    logic [4:0]      dist_calc;

    // Absolute difference of two unsigned 4-bit coordinates.
    function automatic logic [3:0] abs_diff(input logic [3:0] a, input logic [3:0] b);
        logic signed [4:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        return (d < 0) ? 4'(-d) : 4'(d);
    endfunction

`ifdef KNN_EUCLID_EN
    // Clamp the squared distance so the sorter's sentinel (31) is unreachable.
    function automatic logic [4:0] sat_dist(input logic [8:0] v);
        return (v >= 9'd30) ? 5'd30 : v[4:0];
    endfunction

    function automatic logic [4:0] point_dist(input logic [3:0] ax, input logic [3:0] ay,
                                              input logic [3:0] bx, input logic [3:0] by);
        logic [8:0] dx9;
        logic [8:0] dy9;
        dx9 = {5'b0, abs_diff(ax, bx)};
        dy9 = {5'b0, abs_diff(ay, by)};
        return sat_dist(dx9 * dx9 + dy9 * dy9);
    endfunction
`else
    // Maximum 15 + 15 = 30, so no clamping is needed.
    function automatic logic [4:0] point_dist(input logic [3:0] ax, input logic [3:0] ay,
                                              input logic [3:0] bx, input logic [3:0] by);
        return {1'b0, abs_diff(ax, bx)} + {1'b0, abs_diff(ay, by)};
    endfunction
`endif

    // Writes and starts are only accepted while idle, so the table is frozen
    // for the whole duration of a query.
    assign wr_ok    = wr_en && (state_q == S_IDLE);
    assign start_ok = start && (state_q == S_IDLE);

    // Table payload carries no reset; only the valid bits define contents.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            tbl_x[wr_addr]   <= wr_x;
            tbl_y[wr_addr]   <= wr_y;
            tbl_lbl[wr_addr] <= wr_label;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tbl_vld_q <= '0;
        end else if (wr_ok) begin
            tbl_vld_q[wr_addr] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (start_ok) begin
            qx_q <= query_x;
            qy_q <= query_y;
        end
    end

    // Control FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        drain_d = drain_q;
        knn_clr = 1'b0;
        done    = 1'b0;
        busy    = (state_q != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                knn_clr = 1'b1;
                addr_d  = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                // The counter wraps naturally back to 0 after the last address.
                addr_d = addr_q + AW'(1);
                if (addr_q == AW'(N_SAMPLES - 1)) begin
                    state_d = S_DRAIN;
                    drain_d = 1'b0;
                end
            end
            S_DRAIN: begin
                drain_d = 1'b1;
                if (drain_q) begin
                    drain_d = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                addr_d  = '0;
                drain_d = 1'b0;
            end
        endcase
    end

    // ---- stage p1: table read at the current address ----
    always_ff @(posedge clk) begin
        x_p1_q   <= tbl_x[addr_q];
        y_p1_q   <= tbl_y[addr_q];
        lbl_p1_q <= tbl_lbl[addr_q];
    end

    // Reads issued outside RUN (CLEAR, DRAIN) must never reach the sorter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1_q <= 1'b0;
        end else begin
            vld_p1_q <= (state_q == S_RUN) && tbl_vld_q[addr_q];
        end
    end

    assign dist_calc = point_dist(qx_q, qy_q, x_p1_q, y_p1_q);

    // ---- stage p2: distance and label, held while not valid ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p2_q  <= 1'b0;
            dist_p2_q <= '0;
            lbl_p2_q  <= '0;
        end else begin
            vld_p2_q <= vld_p1_q;
            if (vld_p1_q) begin
                dist_p2_q <= dist_calc;
                lbl_p2_q  <= lbl_p1_q;
            end
        end
    end

    assign dist_valid = vld_p2_q;
    assign dist_out   = dist_p2_q;
    assign label_out  = lbl_p2_q;

endmodule
